// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light phase sequencer: state encoding,
// default phase lengths and the phase-order helper.
package light_pkg;

    localparam int LONG_T_DEF  = 8;
    localparam int SHORT_T_DEF = 3;
    localparam int CLR_T_DEF   = 1;
    localparam int TMR_W       = 4;

    typedef enum logic [2:0] {
        S_NG  = 3'd0,
        S_NY  = 3'd1,
        S_AR1 = 3'd2,
        S_EG  = 3'd3,
        S_EY  = 3'd4,
        S_AR2 = 3'd5
    } phase_e;

    // Cyclic successor of a phase; unused codes fall back to north green.
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            S_NG:    n = S_NY;
            S_NY:    n = S_AR1;
            S_AR1:   n = S_EG;
            S_EG:    n = S_EY;
            S_EY:    n = S_AR2;
            default: n = S_NG;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loads a value on strobe, otherwise decrements
// toward zero and saturates there. Everything is frozen while en_i is low.
module phase_timer #(
    parameter int          W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Counter register: reload has priority over decrement, no wrap below 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (en_i) begin
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/light_phase_sequencer.sv
// Two-approach traffic-light sequencer. North holds green until an east car
// is waiting; east green is cut short once its minimum has elapsed and the
// sensor clears. Lamps are decoded purely from the state register.
module light_phase_sequencer
    import light_pkg::*;
#(
    parameter int LONG_T  = LONG_T_DEF,
    parameter int SHORT_T = SHORT_T_DEF,
    parameter int CLR_T   = CLR_T_DEF
) (
    input  logic       clk,
    input  logic       R,
    input  logic       C,
    input  logic       EN,
    output logic       NR,
    output logic       NG,
    output logic       NY,
    output logic       ER,
    output logic       EG,
    output logic       EY,
    output logic [2:0] phase,
    output logic [3:0] tmr
);

    localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(LONG_T - 1);
    localparam logic [TMR_W-1:0] SHORT_LD = TMR_W'(SHORT_T - 1);
    localparam logic [TMR_W-1:0] CLR_LD   = TMR_W'(CLR_T - 1);
    // East green may end early once the count has fallen to this value,
    // i.e. after SHORT_T cycles of green.
    localparam logic [TMR_W-1:0] EG_EARLY = TMR_W'(LONG_T - SHORT_T);

    phase_e             state_q, state_d;
    logic               load_d;
    logic [TMR_W-1:0]   load_val_d;
    logic [TMR_W-1:0]   tmr_cnt;
    logic               tmr_zero;

    phase_timer #(
        .W       (TMR_W),
        .RST_VAL (LONG_LD)
    ) u_timer (
        .clk        (clk),
        .rst        (R),
        .en_i       (EN),
        .load_i     (load_d),
        .load_val_i (load_val_d),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    // State register; reset aborts any phase straight back to north green.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= S_NG;
        end else if (EN) begin
            state_q <= state_d;
        end
    end

    // Next-state decision and timer reload, taken on the same edge.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (EN) begin
            case (state_q)
                S_NG: begin
                    if (tmr_zero && C) begin
                        state_d = next_phase(state_q);
                        load_d  = 1'b1;
                    end
                end
                S_EG: begin
                    if (tmr_zero || (!C && (tmr_cnt <= EG_EARLY))) begin
                        state_d = next_phase(state_q);
                        load_d  = 1'b1;
                    end
                end
                default: begin
                    if (tmr_zero) begin
                        state_d = next_phase(state_q);
                        load_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    // Reload value is the length of the phase being entered, minus one.
    always_comb begin
        load_val_d = CLR_LD;
        case (state_d)
            S_NG, S_EG: load_val_d = LONG_LD;
            S_NY, S_EY: load_val_d = SHORT_LD;
            default:    load_val_d = CLR_LD;
        endcase
    end

    // Moore lamp decode: one lamp per approach, greens mutually exclusive.
    always_comb begin
        NR = 1'b0; NG = 1'b0; NY = 1'b0;
        ER = 1'b0; EG = 1'b0; EY = 1'b0;
        case (state_q)
            S_NG:    begin NG = 1'b1; ER = 1'b1; end
            S_NY:    begin NY = 1'b1; ER = 1'b1; end
            S_EG:    begin NR = 1'b1; EG = 1'b1; end
            S_EY:    begin NR = 1'b1; EY = 1'b1; end
            default: begin NR = 1'b1; ER = 1'b1; end
        endcase
    end

    assign phase = state_q;
    assign tmr   = tmr_cnt;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Scoreboard bench for the light phase sequencer: a phase/age reference model
// predicts each post-edge state, a monitor compares it after every edge.
module tb_light_phase_sequencer;

    localparam int LONG_T  = 8;
    localparam int SHORT_T = 3;
    localparam int CLR_T   = 1;

    logic       clk = 1'b0;
    logic       R, C, EN;
    logic       NR, NG, NY, ER, EG, EY;
    logic [2:0] phase;
    logic [3:0] tmr;

    light_phase_sequencer #(
        .LONG_T  (LONG_T),
        .SHORT_T (SHORT_T),
        .CLR_T   (CLR_T)
    ) dut (
        .clk   (clk),
        .R     (R),
        .C     (C),
        .EN    (EN),
        .NR    (NR),
        .NG    (NG),
        .NY    (NY),
        .ER    (ER),
        .EG    (EG),
        .EY    (EY),
        .phase (phase),
        .tmr   (tmr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int tmr;
        int lamps;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    // Reference model: phase index in cyclic order plus cycles spent in it.
    int m_p   = 0;
    int m_age = 0;

    function automatic int plen(input int p);
        case (p)
            0, 3:    return LONG_T;
            1, 4:    return SHORT_T;
            default: return CLR_T;
        endcase
    endfunction

    function automatic int mtmr();
        int t;
        t = plen(m_p) - 1 - m_age;
        return (t < 0) ? 0 : t;
    endfunction

    // Lamp pattern {NR,NG,NY,ER,EG,EY} for a phase index.
    function automatic int lamp_of(input int p);
        case (p)
            0:       return 6'b010_100;
            1:       return 6'b001_100;
            3:       return 6'b100_010;
            4:       return 6'b100_001;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic model_step(input bit c, input bit en);
        int  t;
        bit  leave;
        if (!en) return;
        t = mtmr();
        case (m_p)
            0:       leave = (t == 0) && c;
            3:       leave = (t == 0) || (!c && (t <= LONG_T - SHORT_T));
            default: leave = (t == 0);
        endcase
        if (leave) begin
            m_p   = (m_p + 1) % 6;
            m_age = 0;
        end else if (t > 0) begin
            m_age++;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.phase = m_p;
        e.tmr   = mtmr();
        e.lamps = lamp_of(m_p);
        return e;
    endfunction

    // One transaction: inputs applied mid-cycle, predicted result queued.
    task automatic drive(input bit c, input bit en);
        @(negedge clk);
        C  = c;
        EN = en;
        model_step(c, en);
        exp_q.push_back(cur_exp());
    endtask

    // Asynchronous reset pulse, checked without waiting for a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        EN = 1'b0;
        R  = 1'b1;
        #1;
        chk("reset_phase", int'(phase), 0);
        chk("reset_tmr", int'(tmr), LONG_T - 1);
        chk("reset_lamps", int'({NR, NG, NY, ER, EG, EY}), 6'b010_100);
        $display("txn reset: phase=%0d tmr=%0d lamps=%b", phase, tmr, {NR, NG, NY, ER, EG, EY});
        m_p   = 0;
        m_age = 0;
        @(negedge clk);
        R = 1'b0;
        exp_q.push_back(cur_exp());
    endtask

    // Drive with a car present until the model reaches the given phase/tmr.
    task automatic run_until(input int p, input int t, input bit c);
        int k;
        k = 0;
        while (!(m_p == p && (t < 0 || mtmr() == t)) && k < 100) begin
            drive(c, 1'b1);
            k++;
        end
        if (k >= 100) chk("run_until_timeout", k, 0);
    endtask

    // Monitor: after every edge, pop the prediction and compare.
    initial begin
        exp_t e;
        int   nl, el;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: C=%0b EN=%0b phase=%0d/%0d tmr=%0d/%0d lamps=%b",
                         n_txn, C, EN, phase, e.phase, tmr, e.tmr, {NR, NG, NY, ER, EG, EY});
                chk("phase", int'(phase), e.phase);
                chk("tmr", int'(tmr), e.tmr);
                chk("lamps", int'({NR, NG, NY, ER, EG, EY}), e.lamps);
                nl = int'(NR) + int'(NG) + int'(NY);
                el = int'(ER) + int'(EG) + int'(EY);
                chk("safety", int'(!(NG && EG) && nl == 1 && el == 1), 1);
            end
        end
    end

    initial begin
        bit c_r;
        R  = 1'b1;
        C  = 1'b0;
        EN = 1'b0;
        #12;
        chk("init_phase", int'(phase), 0);
        chk("init_tmr", int'(tmr), LONG_T - 1);
        chk("init_lamps", int'({NR, NG, NY, ER, EG, EY}), 6'b010_100);
        @(negedge clk);
        R = 1'b0;
        exp_q.push_back(cur_exp());

        // No car: north green forever, timer parks at 0.
        repeat (30) drive(1'b0, 1'b1);

        // Full cycle with a car present from reset.
        do_reset();
        repeat (26) drive(1'b1, 1'b1);

        // Early east exit: sensor clears as east green begins.
        do_reset();
        run_until(3, -1, 1'b1);
        repeat (6) drive(1'b0, 1'b1);

        // Freeze at tmr=1 in north yellow, toggling C while frozen.
        do_reset();
        run_until(1, 1, 1'b1);
        repeat (5) drive(1'($urandom_range(0, 1)), 1'b0);
        repeat (4) drive(1'b1, 1'b1);

        // Reset during east green aborts the phase.
        run_until(3, -1, 1'b1);
        drive(1'b1, 1'b1);
        do_reset();

        // Randomized traffic.
        c_r = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 20) c_r = ~c_r;
            if ($urandom_range(0, 99) < 1) do_reset();
            else drive(c_r, $urandom_range(0, 99) < 85);
        end

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/light_phase_sequencer.md
LIGHT_PHASE_SEQUENCER -- requirements
Module: light_phase_sequencer

Interface
REQ-001 Parameter LONG_T, default 8, minimum/maximum green length in clk cycles.
REQ-002 Parameter SHORT_T, default 3, yellow length and minimum east-green length in cycles.
REQ-003 Parameter CLR_T, default 1, all-red clearance length in cycles.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port R  input  1  reset, asynchronous, active-high.
REQ-006 Port C  input  1  east-approach car sensor; 1 means a car is waiting.
REQ-007 Port EN  input  1  count/advance enable; 0 freezes timer and state.
REQ-008 Ports NR, NG, NY  output  1 each  north red/green/yellow lamps.
REQ-009 Ports ER, EG, EY  output  1 each  east red/green/yellow lamps.
REQ-010 Port phase  output  3  current state encoding.
REQ-011 Port tmr  output  4  current timer value.

Function
REQ-012 The FSM SHALL have six states: S_NG, S_NY, S_AR1, S_EG, S_EY, S_AR2, in the cyclic order S_NG→S_NY→S_AR1→S_EG→S_EY→S_AR2→S_NG.
REQ-013 Lamp outputs SHALL be Moore-decoded from the state register, with no combinational path from C or EN.
REQ-014 Exactly one north lamp and exactly one east lamp SHALL be 1 in every state; both greens SHALL never be 1 together.
REQ-015 Lamp map: S_NG → NG, ER; S_NY → NY, ER; S_AR1/S_AR2 → NR, ER; S_EG → NR, EG; S_EY → NR, EY.
REQ-016 On entry to a state, the timer SHALL load phase length minus 1: LONG_T-1 for greens, SHORT_T-1 for yellows, CLR_T-1 for all-reds.
REQ-017 On each edge with EN=1 and tmr>0, tmr SHALL decrement by 1; tmr SHALL never wrap below 0.
REQ-018 S_NG SHALL exit on the edge where EN=1, tmr==0 and C=1.
REQ-019 In S_NG with tmr==0 and C=0, the state SHALL hold and tmr SHALL hold at 0 indefinitely.
REQ-020 S_EG SHALL exit on the edge where EN=1 and either tmr==0, or C=0 and tmr<=LONG_T-SHORT_T.
REQ-021 The S_EG exit rule gives a minimum east green of SHORT_T cycles and a maximum of LONG_T cycles.
REQ-022 S_NY, S_EY, S_AR1 and S_AR2 SHALL exit unconditionally on the edge where EN=1 and tmr==0.
REQ-023 Every state transition and its timer load SHALL occur on the same edge; there SHALL be no idle cycle between phases.
REQ-024 With EN=0, state and tmr SHALL hold regardless of C; C changes while frozen SHALL have no effect until EN returns to 1.
REQ-025 When C and EN change on the same edge as tmr reaches 0, the exit rules SHALL use the values sampled at the edge where tmr==0 is already registered.

Reset
REQ-026 While R=1 (asynchronously): state=S_NG, tmr=LONG_T-1, NG=1, ER=1, all other lamps 0.
REQ-027 Reset asserted mid-phase SHALL abort that phase immediately, with no yellow or all-red passage.
REQ-028 On the first edge after R deasserts, normal counting SHALL resume.

Structure
REQ-029 The state encoding localparams and the default timing constants SHALL reside in shared package light_pkg.
REQ-030 The timer SHALL be a separate sub-module, phase_timer: load value, load strobe, enable; outputs count and zero flag.
REQ-031 The FSM and lamp decode SHALL reside in light_phase_sequencer.
REQ-032 The RTL SHALL contain no latches and a single always block per register group.

Verification
REQ-033 Reset: pulse R during S_EG → NG=1, ER=1, phase=S_NG, tmr=7 immediately, without waiting for clk.
REQ-034 No car: C=0, EN=1 for 30 cycles → S_NG throughout, tmr reaches 0 at cycle 7 and holds.
REQ-035 Full cycle: C=1, EN=1 from reset → NG 8, NY 3, AR1 1, EG 8, EY 3, AR2 1 cycles; back to S_NG at cycle 24.
REQ-036 Early east exit: C drops to 0 on entry to S_EG → EG lasts exactly 3 cycles, then S_EY.
REQ-037 Freeze: EN=0 for 5 cycles at tmr=1 in S_NY → phase and tmr unchanged; S_AR1 is entered 2 enabled edges after EN returns.
REQ-038 Safety assertion, checked every cycle of all scenarios: !(NG&&EG), exactly one north lamp high, exactly one east lamp high.
